// File: rtl/nibble_stream_packer.sv
// nibble_stream_packer
//   Packs a stream of NIB_W-bit nibbles (qualified by valid) into OUT_W-bit
//   words, queues them in a DEPTH-entry FIFO, and shows either the FIFO head
//   or a running modulo-2^OUT_W checksum of accepted words on dout.
//
// Ports
//   clk         clock, all state on the rising edge
//   reset       asynchronous, active-low clear of all state
//   din         nibble data, sampled when valid=1
//   valid       nibble strobe, one nibble per high cycle
//   toggle      level input; each 0->1 edge flips the display mode
//   pop         consume FIFO head (ignored when empty)
//   dout        mode 0: FIFO head (0 if empty); mode 1: checksum
//   dout_valid  FIFO non-empty
//   full        FIFO holds DEPTH words
//   overflow    sticky: a completed word was dropped
//   mode        current display mode
//
// Build option
//   PACKER_TIMEOUT_EN  when defined, a partial word idle for TIMEOUT cycles
//                      is flushed with its missing low nibbles zero-padded.
//
// Assembly FSM (state = nib_cnt)
//   state       | meaning
//   FILL(0)     | no nibbles held, waiting for the first of a word
//   FILL(k>0)   | k nibbles held in sr (oldest in the most significant slot)
//   FILL(NIBS-1)| next valid nibble completes the word and pushes it

module nibble_stream_packer #(
    parameter int NIB_W   = 4,
    parameter int NIBS    = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NIB_W-1:0]        din,
    input  logic                    valid,
    input  logic                    toggle,
    input  logic                    pop,
    output logic [NIB_W*NIBS-1:0]   dout,
    output logic                    dout_valid,
    output logic                    full,
    output logic                    overflow,
    output logic                    mode
);

    localparam int OUT_W = NIB_W * NIBS;
    localparam int SRW   = OUT_W - NIB_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBS - 1);

    logic [CW-1:0]    nib_cnt;
    logic [SRW-1:0]   sr;
    logic [OUT_W-1:0] sr_ext;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [OUT_W-1:0] sum;
    logic             toggle_q;

    logic             push_req;
    logic [OUT_W-1:0] push_word;
    logic             pop_ok;
    logic             push_ok;

    // Held nibbles followed by the incoming one; also the shift-register next value.
    assign sr_ext = {sr, din};

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]    idle_cnt;
    logic             flush;
    logic [OUT_W-1:0] pad_word;
    int               flush_shift;

    // idle_cnt counts down from TIMEOUT; the flush fires on the TIMEOUT-th idle cycle.
    assign flush = !valid && (nib_cnt != '0) && (idle_cnt == TW'(1));

    always_comb begin
        flush_shift = NIB_W * (NIBS - int'(nib_cnt));
        pad_word    = {{NIB_W{1'b0}}, sr} << flush_shift;
    end
`endif

    always_comb begin
        push_req  = valid && (nib_cnt == LAST);
        push_word = sr_ext;
`ifdef PACKER_TIMEOUT_EN
        if (flush) begin
            push_req  = 1'b1;
            push_word = pad_word;
        end
`endif
    end

    assign full       = (count == (AW+1)'(DEPTH));
    assign dout_valid = (count != '0);
    assign pop_ok     = pop && dout_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push_req && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nib_cnt <= '0;
            sr      <= '0;
        end else if (valid) begin
            if (nib_cnt == LAST) begin
                nib_cnt <= '0;
                sr      <= '0;
            end else begin
                nib_cnt <= nib_cnt + 1'b1;
                sr      <= sr_ext[SRW-1:0];
            end
`ifdef PACKER_TIMEOUT_EN
        end else if (flush) begin
            nib_cnt <= '0;
            sr      <= '0;
`endif
        end
    end

`ifdef PACKER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= TW'(TIMEOUT);
        end else if (valid || (nib_cnt == '0) || flush) begin
            idle_cnt <= TW'(TIMEOUT);
        end else begin
            idle_cnt <= idle_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                sum    <= sum + push_word;
            end else if (push_req) begin
                overflow <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggle_q <= 1'b0;
            mode     <= 1'b0;
        end else begin
            toggle_q <= toggle;
            if (toggle && !toggle_q) begin
                mode <= ~mode;
            end
        end
    end

    always_comb begin
        if (mode) begin
            dout = sum;
        end else if (dout_valid) begin
            dout = mem[rd_ptr];
        end else begin
            dout = '0;
        end
    end

endmodule

// File: tb/tb_nibble_stream_packer.sv
module tb_nibble_stream_packer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       valid;
    logic       toggle;
    logic       pop;
    logic [7:0] dout;
    logic       dout_valid;
    logic       full;
    logic       overflow;
    logic       mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbq [$];
    logic [7:0] exp_sum;
    logic       exp_ovf;
    logic       exp_mode;

    nibble_stream_packer #(.NIB_W(4), .NIBS(2), .DEPTH(DEPTH), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .valid      (valid),
        .toggle     (toggle),
        .pop        (pop),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .overflow   (overflow),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_dout;
        if (exp_mode)
            exp_dout = exp_sum;
        else if (sbq.size() > 0)
            exp_dout = sbq[0];
        else
            exp_dout = 8'h00;
        check({tag, "_dout"},       32'(dout),       32'(exp_dout));
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'(sbq.size() > 0));
        check({tag, "_full"},       32'(full),       32'(sbq.size() == DEPTH));
        check({tag, "_overflow"},   32'(overflow),   32'(exp_ovf));
        check({tag, "_mode"},       32'(mode),       32'(exp_mode));
    endtask

    task automatic do_reset(input string tag);
        reset  = 1'b0;
        valid  = 1'b0;
        pop    = 1'b0;
        toggle = 1'b0;
        din    = 4'h0;
        sbq.delete();
        exp_sum  = 8'h00;
        exp_ovf  = 1'b0;
        exp_mode = 1'b0;
        #2;
        check_all(tag);
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    // Two-nibble word, MSB nibble first; optional pop alongside the final nibble.
    task automatic send_word(input logic [7:0] w, input logic with_pop);
        logic pop_ok;
        valid = 1'b1;
        din   = w[7:4];
        tick;
        din    = w[3:0];
        pop    = with_pop;
        pop_ok = with_pop && (sbq.size() > 0);
        if (pop_ok && !exp_mode)
            check("pushpop_head", 32'(dout), 32'(sbq[0]));
        tick;
        valid = 1'b0;
        pop   = 1'b0;
        if (pop_ok)
            void'(sbq.pop_front());
        if (sbq.size() < DEPTH) begin
            sbq.push_back(w);
            exp_sum = exp_sum + w;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic do_pop(input string tag);
        check({tag, "_pre"}, 32'(dout), 32'((sbq.size() > 0) ? sbq[0] : 8'h00));
        pop = 1'b1;
        tick;
        pop = 1'b0;
        if (sbq.size() > 0)
            void'(sbq.pop_front());
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        toggle = 1'b0;
        pop = 1'b0;
        din = 4'h0;
        #3;
        do_reset("rst");
        check_all("after_rst");

        // 1: basic pack and pop
        send_word(8'hA5, 1'b0);
        check_all("t1_push");
        do_pop("t1_pop");
        do_pop("t1_pop_empty");

        // 2: fill, overflow drop, ordered drain (write pointer wraps)
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        check_all("t2_three");
        send_word(8'h44, 1'b0);
        check_all("t2_full");
        send_word(8'h55, 1'b0);
        check_all("t2_drop");
        do_pop("t2_pop1");
        do_pop("t2_pop2");
        do_pop("t2_pop3");
        do_pop("t2_pop4");

        // 3: push and pop together while full
        do_reset("t3_rst");
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        send_word(8'h66, 1'b1);
        check_all("t3_pushpop");
        do_pop("t3_pop1");
        do_pop("t3_pop2");
        do_pop("t3_pop3");
        do_pop("t3_pop4");
        send_word(8'h3C, 1'b0);
        check_all("t3_wrap");

        // 4: checksum display and toggle edge detection
        do_reset("t4_rst");
        send_word(8'hF0, 1'b0);
        send_word(8'h20, 1'b0);
        toggle = 1'b1;
        tick;
        exp_mode = 1'b1;
        check_all("t4_mode1");
        repeat (10) tick;
        check_all("t4_held");
        toggle = 1'b0;
        tick;
        check_all("t4_release");
        toggle = 1'b1;
        send_word(8'h07, 1'b0);
        exp_mode = 1'b0;
        toggle = 1'b0;
        check_all("t4_valid_and_toggle");

        // 5: reset in the middle of a word
        valid = 1'b1;
        din = 4'h7;
        tick;
        valid = 1'b0;
        do_reset("t5_rst");
        check_all("t5_after_rst");
        send_word(8'h12, 1'b0);
        check_all("t5_word");

        // 6: lone nibble followed by a long idle stretch
        do_reset("t6_rst");
        valid = 1'b1;
        din = 4'h9;
        tick;
        valid = 1'b0;
`ifdef PACKER_TIMEOUT_EN
        begin
            int waited = 0;
            while (!dout_valid && waited < 40) begin
                tick;
                waited++;
            end
            check("t6_flush_in_time", 32'(waited <= 16), 32'd1);
            sbq.push_back(8'h90);
            exp_sum = exp_sum + 8'h90;
            check_all("t6_flush");
        end
`else
        repeat (20) tick;
        check_all("t6_held");
        valid = 1'b1;
        din = 4'h3;
        tick;
        valid = 1'b0;
        sbq.push_back(8'h93);
        exp_sum = exp_sum + 8'h93;
        check_all("t6_complete");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
